// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Time-multiplexed driver for a four-digit, common-anode seven-segment
// display. It lights one digit at a time for DWELL_CYCLES clocks. Between
// digits there are GUARD_CYCLES clocks with every anode off, which
// prevents ghosting.
//
// Digit values and decimal-point requests are captured once per frame,
// just as digit 0 lights, so a frame never mixes old and new values.
//
// Build option: define SEG_SCAN_DRIVER_LZB_EN to enable leading-zero
// blanking. A zero digit in positions 3..1 is dark when every more
// significant digit is also zero. Digit 0 is never blanked. Without the
// macro, every digit is decoded and no blanking logic exists.
`timescale 1ns/1ps

module seg_scan_driver #(
  parameter int DWELL_CYCLES = 100000,
  parameter int GUARD_CYCLES = 4
) (
  input  logic        seg_scan_driver_clk,
  input  logic        seg_scan_driver_rst_n,
  input  logic        seg_scan_driver_enable,
  input  logic [15:0] seg_scan_driver_digits,
  input  logic [3:0]  seg_scan_driver_dp_mask,
  output logic [3:0]  seg_scan_driver_anode_n,
  output logic [6:0]  seg_scan_driver_seg_n,
  output logic        seg_scan_driver_dp_n,
  output logic        seg_scan_driver_frame_done
);

  // The timer counts 0 .. (longest phase - 1), so clog2 of the longer phase suffices.
  localparam int MAX_CYCLES = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
  localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] GUARD_LAST = TW'(GUARD_CYCLES - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic {
    S_GUARD = 1'b0,
    S_DWELL = 1'b1
  } state_t;

  // Registered state
  state_t          r_state;
  logic [1:0]      r_idx;
  logic [TW-1:0]   r_timer;
  logic [15:0]     r_shadow_digits;
  logic [3:0]      r_shadow_dp;

  // Registered outputs
  logic [3:0]      r_anode_n;
  logic [6:0]      r_seg_n;
  logic            r_dp_n;
  logic            r_frame_done;

  // Next-state values
  state_t          w_state_next;
  logic [1:0]      w_idx_next;
  logic [TW-1:0]   w_timer_next;
  logic [15:0]     w_shadow_digits_next;
  logic [3:0]      w_shadow_dp_next;
  logic            w_frame_done_next;

  // Next output values, computed from the next state so each output is valid on the first cycle of its state
  logic [3:0]      w_anode_n_next;
  logic [6:0]      w_seg_n_next;
  logic            w_dp_n_next;
  logic [6:0]      w_digit_seg [4];

  // BCD to active-low {g,f,e,d,c,b,a}; codes 10-15 become a dash.
  function automatic logic [6:0] f_decode(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

  // Next-state logic: guard/dwell sequencing, digit advance, and the frame-start shadow capture.
  always_comb begin
    w_state_next         = r_state;
    w_idx_next           = r_idx;
    w_timer_next         = r_timer + 1'b1;
    w_shadow_digits_next = r_shadow_digits;
    w_shadow_dp_next     = r_shadow_dp;
    w_frame_done_next    = 1'b0;

    if (!seg_scan_driver_enable) begin
      // Disabled: park in guard at digit 0 so re-enabling always begins with a full guard.
      w_state_next = S_GUARD;
      w_idx_next   = 2'd0;
      w_timer_next = '0;
    end else begin
      case (r_state)
        S_GUARD: begin
          if (r_timer == GUARD_LAST) begin
            w_state_next = S_DWELL;
            w_timer_next = '0;
            if (r_idx == 2'd0) begin
              w_shadow_digits_next = seg_scan_driver_digits;
              w_shadow_dp_next     = seg_scan_driver_dp_mask;
            end
          end
        end
        S_DWELL: begin
          if (r_timer == DWELL_LAST) begin
            w_state_next      = S_GUARD;
            w_timer_next      = '0;
            w_idx_next        = r_idx + 2'd1;
            w_frame_done_next = (r_idx == 2'd3);
          end
        end
        default: begin
          w_state_next = S_GUARD;
          w_idx_next   = 2'd0;
          w_timer_next = '0;
        end
      endcase
    end
  end

  // Per-digit segment patterns, decoded from the shadow value that will be current next cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic [3:0] w_nibble;
      assign w_nibble = w_shadow_digits_next[gi*4 +: 4];
`ifdef SEG_SCAN_DRIVER_LZB_EN
      if (gi == 0) begin : g_no_blank
        assign w_digit_seg[gi] = f_decode(w_nibble);
      end else begin : g_lzb
        logic w_leading_zero;
        // Blank when this digit and every more significant digit are zero.
        assign w_leading_zero  = (w_shadow_digits_next[15:gi*4] == '0);
        assign w_digit_seg[gi] = w_leading_zero ? SEG_BLANK : f_decode(w_nibble);
      end
`else
      assign w_digit_seg[gi] = f_decode(w_nibble);
`endif
    end
  endgenerate

  // Output values for the upcoming cycle: one anode and its pattern in dwell, everything dark in guard.
  always_comb begin
    w_anode_n_next = 4'hF;
    w_seg_n_next   = SEG_BLANK;
    w_dp_n_next    = 1'b1;
    if (w_state_next == S_DWELL) begin
      w_anode_n_next[w_idx_next] = 1'b0;
      w_seg_n_next               = w_digit_seg[w_idx_next];
      w_dp_n_next                = ~w_shadow_dp_next[w_idx_next];
    end
  end

  // State register; reset overrides enable and every transition.
  always_ff @(posedge seg_scan_driver_clk) begin
    if (!seg_scan_driver_rst_n) begin
      r_state         <= S_GUARD;
      r_idx           <= 2'd0;
      r_timer         <= '0;
      r_shadow_digits <= 16'h0000;
      r_shadow_dp     <= 4'h0;
    end else begin
      r_state         <= w_state_next;
      r_idx           <= w_idx_next;
      r_timer         <= w_timer_next;
      r_shadow_digits <= w_shadow_digits_next;
      r_shadow_dp     <= w_shadow_dp_next;
    end
  end

  // Output registers, so the pins are glitch-free.
  always_ff @(posedge seg_scan_driver_clk) begin
    if (!seg_scan_driver_rst_n) begin
      r_anode_n    <= 4'hF;
      r_seg_n      <= SEG_BLANK;
      r_dp_n       <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_anode_n    <= w_anode_n_next;
      r_seg_n      <= w_seg_n_next;
      r_dp_n       <= w_dp_n_next;
      r_frame_done <= w_frame_done_next;
    end
  end

  assign seg_scan_driver_anode_n    = r_anode_n;
  assign seg_scan_driver_seg_n      = r_seg_n;
  assign seg_scan_driver_dp_n       = r_dp_n;
  assign seg_scan_driver_frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver with DWELL_CYCLES=4 and GUARD_CYCLES=2.
// Each frame is described by a table row of input values plus hand-decoded
// segment patterns. The stimulus tasks push one expected output record per
// clock into a scoreboard queue. A monitor pops the records and compares
// them on the falling edge.
`timescale 1ns/1ps

module tb_seg_scan_driver;

  localparam int DW = 4;
  localparam int GD = 2;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SB = 7'h7F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic [3:0]  anode_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_done;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .DWELL_CYCLES(DW),
    .GUARD_CYCLES(GD)
  ) dut (
    .seg_scan_driver_clk       (clk),
    .seg_scan_driver_rst_n     (rst_n),
    .seg_scan_driver_enable    (enable),
    .seg_scan_driver_digits    (digits),
    .seg_scan_driver_dp_mask   (dp_mask),
    .seg_scan_driver_anode_n   (anode_n),
    .seg_scan_driver_seg_n     (seg_n),
    .seg_scan_driver_dp_n      (dp_n),
    .seg_scan_driver_frame_done(frame_done)
  );

  typedef struct {
    string      tag;
    logic [3:0] an;
    logic [6:0] sg;
    logic       dp;
    logic       fd;
  } exp_t;

  // One frame of stimulus. seg holds the expected patterns {d3,d2,d1,d0}.
  // chg_digit >= 0 rewrites the digits input during that digit's dwell.
  typedef struct {
    string       tag;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    int          chg_digit;
    logic [15:0] chg_value;
    logic [27:0] seg;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input string tag, input logic [15:0] d, input logic [3:0] dp,
                              input int chg, input logic [15:0] chg_v,
                              input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0);
    vec_t v;
    v.tag       = tag;
    v.digits    = d;
    v.dp_mask   = dp;
    v.chg_digit = chg;
    v.chg_value = chg_v;
    v.seg       = {s3, s2, s1, s0};
    return v;
  endfunction

  // Records what the DUT should present after the next rising edge.
  task automatic expect_cyc(input string tag, input logic [3:0] an, input logic [6:0] sg,
                            input logic dp, input logic fd);
    exp_t e;
    @(posedge clk);
    #1;
    e.tag = tag;
    e.an  = an;
    e.sg  = sg;
    e.dp  = dp;
    e.fd  = fd;
    sb_q.push_back(e);
  endtask

  task automatic expect_blank(input string tag, input int n);
    for (int i = 0; i < n; i++) expect_cyc(tag, 4'hF, SB, 1'b1, 1'b0);
  endtask

  // Drives one frame starting at digit 0's dwell. It stops early after max_cycles.
  task automatic run_frame(input vec_t v, input int max_cycles);
    int         n;
    logic [3:0] an;
    logic [6:0] sg;
    n       = 0;
    digits  = v.digits;
    dp_mask = v.dp_mask;
    $display("frame %s: digits=%h dp_mask=%b", v.tag, v.digits, v.dp_mask);
    for (int d = 0; d < 4; d++) begin
      an    = 4'hF;
      an[d] = 1'b0;
      sg    = v.seg[d*7 +: 7];
      for (int c = 0; c < DW; c++) begin
        if (n >= max_cycles) return;
        expect_cyc({v.tag, " dwell"}, an, sg, ~v.dp_mask[d], 1'b0);
        n++;
        if (d == v.chg_digit && c == 0) digits = v.chg_value;
      end
      for (int c = 0; c < GD; c++) begin
        if (n >= max_cycles) return;
        expect_cyc({v.tag, " guard"}, 4'hF, SB, 1'b1, (d == 3 && c == 0));
        n++;
      end
    end
  endtask

  // Scoreboard checker
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      if ({anode_n, seg_n, dp_n, frame_done} !== {e.an, e.sg, e.dp, e.fd}) begin
        errors++;
        $display("FAIL %s @%0t: got anode_n=%b seg_n=%b dp_n=%b frame_done=%b, want anode_n=%b seg_n=%b dp_n=%b frame_done=%b",
                 e.tag, $time, anode_n, seg_n, dp_n, frame_done, e.an, e.sg, e.dp, e.fd);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, want completion");
    $fatal(1, "watchdog");
  end

  vec_t vecs[9];
  vec_t v_drop;

  initial begin
    vecs[0] = mk("1234",     16'h1234, 4'b0000, -1, 16'h0000, S1, S2, S3, S4);
    vecs[1] = mk("tearing",  16'h1234, 4'b0000,  1, 16'h9999, S1, S2, S3, S4);
    vecs[2] = mk("9999",     16'h9999, 4'b0000, -1, 16'h0000, S9, S9, S9, S9);
    vecs[3] = mk("FA00",     16'hFA00, 4'b0100, -1, 16'h0000, SD, SD, S0, S0);
    vecs[4] = mk("5678",     16'h5678, 4'b1011, -1, 16'h0000, S5, S6, S7, S8);
    vecs[5] = mk("CDEB",     16'hCDEB, 4'b0000, -1, 16'h0000, SD, SD, SD, SD);
`ifdef SEG_SCAN_DRIVER_LZB_EN
    vecs[6] = mk("0050 lzb", 16'h0050, 4'b0000, -1, 16'h0000, SB, SB, S5, S0);
    vecs[7] = mk("0000 lzb", 16'h0000, 4'b1001, -1, 16'h0000, SB, SB, SB, S0);
    vecs[8] = mk("0907 lzb", 16'h0907, 4'b0000, -1, 16'h0000, SB, S9, S0, S7);
`else
    vecs[6] = mk("0050",     16'h0050, 4'b0000, -1, 16'h0000, S0, S0, S5, S0);
    vecs[7] = mk("0000",     16'h0000, 4'b1001, -1, 16'h0000, S0, S0, S0, S0);
    vecs[8] = mk("0907",     16'h0907, 4'b0000, -1, 16'h0000, S0, S9, S0, S7);
`endif
    v_drop  = mk("8421",     16'h8421, 4'b0001, -1, 16'h0000, S8, S4, S2, S1);

    // Reset with enable already high: outputs stay dark while reset is held.
    rst_n   = 1'b0;
    enable  = 1'b1;
    digits  = 16'h1234;
    dp_mask = 4'b0000;
    expect_blank("reset", 3);
    rst_n = 1'b1;
    // The cycle right after release is the first guard cycle.
    expect_blank("post-reset guard", GD - 1);

    // Back-to-back frames from the table
    for (int i = 0; i < 9; i++) run_frame(vecs[i], 1000);

    // Drop enable during digit 2's dwell: anodes go dark at once and no frame pulse follows.
    run_frame(v_drop, 2 * (DW + GD) + 2);
    enable = 1'b0;
    expect_blank("enable low", 3);
    enable = 1'b1;
    expect_blank("re-enable guard", GD - 1);
    run_frame(v_drop, 1000);

    // Reset during digit 1's dwell overrides the scan.
    run_frame(vecs[4], DW + GD + 1);
    rst_n = 1'b0;
    expect_blank("reset mid-dwell", 2);
    rst_n = 1'b1;
    expect_blank("post-reset guard 2", GD - 1);
    run_frame(vecs[3], 1000);

    // Let the monitor drain the last record.
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending, want 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
